// File: rtl/dma_unpack_buffer_pkg.sv
// dma_pkg: definitions shared by the DMA unpack buffer files.
//   - DT_* : destination RAM selector codes carried by a transfer descriptor
//   - state_t : controller state encoding (IDLE / ACTIVE / DONE)
//   - clog2 : constant-evaluable ceiling log2 used to size counters and lane indices
package dma_pkg;

    localparam logic [2:0] DT_NONE       = 3'b000;
    localparam logic [2:0] DT_INPUT      = 3'b001;
    localparam logic [2:0] DT_POINT_EVEN = 3'b010;
    localparam logic [2:0] DT_POINT_ODD  = 3'b011;
    localparam logic [2:0] DT_V_RAM      = 3'b100;
    localparam logic [2:0] DT_Z_RAM      = 3'b101;
    localparam logic [2:0] DT_BIAS       = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DONE   = 2'b10
    } state_t;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dma_unpack_buffer_if.sv
// dma_unpack_buffer_if: bundles the descriptor, beat, RAM-write and status
// signals of the DMA unpack buffer.
//   cfg_*      : transfer descriptor handshake (type, RAM base, beat count)
//   in_*       : wide beat handshake
//   ram_*      : destination RAM write port plus its stall input
//   busy/done/err : transfer status
// modport slave is the buffer's view, modport master is the producer/consumer view.
interface dma_unpack_buffer_if
    import dma_pkg::*;
#(
    parameter int DD_WIDTH       = 16,
    parameter int BEAT_WIDTH     = 256,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int MAX_BEATS      = 16,
    parameter int BEAT_CNT_W     = clog2(MAX_BEATS + 1)
);

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [2:0]                cfg_data_type;
    logic [RAM_ADDR_WIDTH-1:0] cfg_ram_base;
    logic [BEAT_CNT_W-1:0]     cfg_beats;
    logic                      in_valid;
    logic                      in_ready;
    logic [BEAT_WIDTH-1:0]     in_data;
    logic                      ram_stall;
    logic                      ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DD_WIDTH-1:0]       ram_data;
    logic [2:0]                ram_selecter;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport slave (
        input  cfg_valid, cfg_data_type, cfg_ram_base, cfg_beats,
        input  in_valid, in_data, ram_stall,
        output cfg_ready, in_ready, ram_we, ram_addr, ram_data, ram_selecter,
        output busy, done, err
    );

    modport master (
        output cfg_valid, cfg_data_type, cfg_ram_base, cfg_beats,
        output in_valid, in_data, ram_stall,
        input  cfg_ready, in_ready, ram_we, ram_addr, ram_data, ram_selecter,
        input  busy, done, err
    );

endinterface

// File: rtl/dma_unpack_buffer_bank.sv
// unpack_bank: one beat-wide holding register with its full flag.
//   clk_h, rst : clock and asynchronous active-high reset
//   load       : capture din and mark the bank full
//   clear      : mark the bank empty (never asserted together with load)
//   din        : incoming beat
//   lane_sel   : lane to present on lane_data
//   full       : registered occupancy flag
//   lane_data  : selected DD_WIDTH lane of the stored beat
module unpack_bank
    import dma_pkg::*;
#(
    parameter int DD_WIDTH   = 16,
    parameter int BEAT_WIDTH = 256,
    parameter int LANES      = BEAT_WIDTH / DD_WIDTH,
    parameter int LANE_W     = clog2(LANES)
) (
    input  logic                  clk_h,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [BEAT_WIDTH-1:0] din,
    input  logic [LANE_W-1:0]     lane_sel,
    output logic                  full,
    output logic [DD_WIDTH-1:0]   lane_data
);

    logic [BEAT_WIDTH-1:0] data_r;
    logic                  full_r;
    logic [DD_WIDTH-1:0]   lanes_s [LANES];

    // Storage and occupancy; reset discards whatever beat was held.
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            data_r <= {BEAT_WIDTH{1'b0}};
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= din;
            full_r <= 1'b1;
        end else if (clear) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lanes_s[k] = data_r[k*DD_WIDTH +: DD_WIDTH];
    end

    assign full      = full_r;
    assign lane_data = lanes_s[lane_sel];

endmodule

// File: rtl/dma_unpack_buffer.sv
// dma_unpack_buffer: accepts wide DMA beats and writes them to a RAM one
// DD_WIDTH word per cycle, lane 0 first, from a programmable base address.
// Two ping-pong banks let the next beat arrive while the current one drains.
//   clk_h : clock (rising edge)
//   rst   : asynchronous active-high reset, aborts any transfer silently
//   bus   : descriptor, beat, RAM-write and status signals (slave view)
module dma_unpack_buffer
    import dma_pkg::*;
#(
    parameter int DD_WIDTH       = 16,
    parameter int BEAT_WIDTH     = 256,
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int MAX_BEATS      = 16,
    localparam int LANES         = BEAT_WIDTH / DD_WIDTH,
    localparam int BEAT_CNT_W    = clog2(MAX_BEATS + 1),
    localparam int LANE_W        = clog2(LANES)
) (
    input logic                clk_h,
    input logic                rst,
    dma_unpack_buffer_if.slave bus
);

    state_t                    state_r;
    logic                      err_r;
    logic [2:0]                type_r;
    logic [BEAT_CNT_W-1:0]     beats_r;
    logic [BEAT_CNT_W-1:0]     beats_acc_r;
    logic [BEAT_CNT_W-1:0]     beats_drn_r;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_r;
    logic [LANE_W-1:0]         lane_r;
    logic                      wr_ptr_r;
    logic                      rd_ptr_r;

    logic [1:0]                full_s;
    logic [1:0]                load_s;
    logic [1:0]                clear_s;
    logic [DD_WIDTH-1:0]       lane_data_s [2];
    logic                      illegal_cfg_s;
    logic                      in_ready_s;
    logic                      in_fire_s;
    logic                      we_s;
    logic                      last_lane_s;
    logic                      beat_done_s;

    assign illegal_cfg_s = (bus.cfg_data_type == DT_NONE)
                        || (bus.cfg_beats == {BEAT_CNT_W{1'b0}})
                        || (bus.cfg_beats > BEAT_CNT_W'(MAX_BEATS));

    // Intake only looks at the registered full flag, so a bank emptied this
    // cycle cannot be refilled until the next one.
    assign in_ready_s  = (state_r == ACTIVE) && (beats_acc_r < beats_r) && !full_s[wr_ptr_r];
    assign in_fire_s   = in_ready_s && bus.in_valid;
    assign we_s        = (state_r == ACTIVE) && full_s[rd_ptr_r] && !bus.ram_stall;
    assign last_lane_s = (lane_r == LANE_W'(LANES - 1));
    assign beat_done_s = we_s && last_lane_s;

    for (genvar i = 0; i < 2; i++) begin : g_bank
        assign load_s[i]  = in_fire_s && (wr_ptr_r == 1'(i));
        assign clear_s[i] = beat_done_s && (rd_ptr_r == 1'(i));

        unpack_bank #(
            .DD_WIDTH   (DD_WIDTH),
            .BEAT_WIDTH (BEAT_WIDTH),
            .LANES      (LANES),
            .LANE_W     (LANE_W)
        ) u_bank (
            .clk_h     (clk_h),
            .rst       (rst),
            .load      (load_s[i]),
            .clear     (clear_s[i]),
            .din       (bus.in_data),
            .lane_sel  (lane_r),
            .full      (full_s[i]),
            .lane_data (lane_data_s[i])
        );
    end

    // Controller: descriptor latch, intake/drain pointers and counters, state.
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            err_r       <= 1'b0;
            type_r      <= 3'b000;
            beats_r     <= {BEAT_CNT_W{1'b0}};
            beats_acc_r <= {BEAT_CNT_W{1'b0}};
            beats_drn_r <= {BEAT_CNT_W{1'b0}};
            ram_addr_r  <= {RAM_ADDR_WIDTH{1'b0}};
            lane_r      <= {LANE_W{1'b0}};
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        type_r      <= bus.cfg_data_type;
                        beats_r     <= bus.cfg_beats;
                        ram_addr_r  <= bus.cfg_ram_base;
                        beats_acc_r <= {BEAT_CNT_W{1'b0}};
                        beats_drn_r <= {BEAT_CNT_W{1'b0}};
                        lane_r      <= {LANE_W{1'b0}};
                        wr_ptr_r    <= 1'b0;
                        rd_ptr_r    <= 1'b0;
                        if (illegal_cfg_s) begin
                            err_r   <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            err_r   <= 1'b0;
                            state_r <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (in_fire_s) begin
                        wr_ptr_r    <= ~wr_ptr_r;
                        beats_acc_r <= beats_acc_r + BEAT_CNT_W'(1);
                    end
                    if (we_s) begin
                        ram_addr_r <= ram_addr_r + RAM_ADDR_WIDTH'(1);
                        if (last_lane_s) begin
                            lane_r      <= {LANE_W{1'b0}};
                            rd_ptr_r    <= ~rd_ptr_r;
                            beats_drn_r <= beats_drn_r + BEAT_CNT_W'(1);
                            if (beats_drn_r == beats_r - BEAT_CNT_W'(1)) begin
                                state_r <= DONE;
                            end
                        end else begin
                            lane_r <= lane_r + LANE_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready    = (state_r == IDLE);
    assign bus.in_ready     = in_ready_s;
    assign bus.ram_we       = we_s;
    assign bus.ram_addr     = ram_addr_r;
    // Banks fill and drain in the same order, so the read bank being empty
    // means both are empty.
    assign bus.ram_data     = full_s[rd_ptr_r] ? lane_data_s[rd_ptr_r] : {DD_WIDTH{1'b0}};
    assign bus.ram_selecter = type_r;
    assign bus.busy         = (state_r != IDLE);
    assign bus.done         = (state_r == DONE);
    assign bus.err          = (state_r == DONE) && err_r;

endmodule

// File: doc/dma_unpack_buffer.md
Name: dma_unpack_buffer

Overview:
Parametrised successor of the DMA write buffer. It accepts wide DMA beats over a valid/ready handshake, splits each beat into DD_WIDTH words and writes them sequentially into the on-chip RAM selected by the transfer's data type. Two ping-pong beat banks let the next beat land while the current one drains, so a multi-beat transfer streams at one word per cycle. A transfer has a programmable beat count and RAM base address.

Parameters:
DD_WIDTH, 16, RAM word width in bits
BEAT_WIDTH, 256, DMA beat width; must be an integer multiple of DD_WIDTH
LANES, BEAT_WIDTH/DD_WIDTH (derived), words per beat; must be a power of two and at least 2
RAM_ADDR_WIDTH, 8, destination RAM address width
MAX_BEATS, 16, largest legal cfg_beats
BEAT_CNT_W, clog2(MAX_BEATS+1) (derived), width of the beat counters

Ports:
clk_h  in  1  clock, all logic on its rising edge
rst  in  1  reset, asynchronous and active-high
cfg_valid  in  1  transfer descriptor valid
cfg_ready  out  1  descriptor accepted when valid and ready are both high
cfg_data_type  in  3  000 none, 001 input, 010 point_even, 011 point_odd, 100 v_ram, 101 z_ram, 110 bias_ram
cfg_ram_base  in  RAM_ADDR_WIDTH  first destination address
cfg_beats  in  BEAT_CNT_W  number of beats in the transfer
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when valid and ready are both high
in_data  in  BEAT_WIDTH  beat; lane k is bits [k*DD_WIDTH +: DD_WIDTH]
ram_stall  in  1  destination RAM cannot take a write this cycle
ram_we  out  1  write strobe
ram_addr  out  RAM_ADDR_WIDTH  write address
ram_data  out  DD_WIDTH  write data
ram_selecter  out  3  latched data type
busy  out  1  high whenever not IDLE
done  out  1  one-cycle pulse when the transfer ends
err  out  1  one-cycle pulse, coincident with done, for an illegal descriptor

Behaviour:
- Reset (asynchronous, active-high): state IDLE; both banks empty; all pointers and counters 0.
- Output values while in reset: cfg_ready=1, in_ready=0, ram_we=0, ram_addr=0, ram_data=0, ram_selecter=0, busy=0, done=0, err=0.
- Reset asserted mid-transfer aborts the transfer immediately. No done is issued and bank contents are discarded.
- States:
  - IDLE: cfg_ready=1. On a cfg handshake, latch type, base and beats.
    - If type==000, cfg_beats==0 or cfg_beats>MAX_BEATS: go to DONE with err set.
    - Otherwise go to ACTIVE.
  - ACTIVE: run intake and drain until the last word of the last beat is written, then go to DONE.
  - DONE: one cycle with done=1 (err=1 for an illegal descriptor), then IDLE. cfg_ready=0 here.
- Intake:
  - in_ready = ACTIVE && beats_accepted<beats && bank[wr_ptr] empty.
  - Empty flags are registered, so a bank freed this cycle is not reusable until the next cycle.
  - On a handshake: the bank captures in_data and is marked full, wr_ptr toggles, beats_accepted increments.
- Drain:
  - ram_we = ACTIVE && bank[rd_ptr] full && !ram_stall (combinational from registered state).
  - ram_data = lane[lane_idx] of bank[rd_ptr], emitted lane 0 first.
  - On each ram_we: ram_addr increments, wrapping modulo 2^RAM_ADDR_WIDTH; lane_idx increments.
  - When lane_idx reaches LANES-1: the bank is marked empty, rd_ptr toggles and lane_idx returns to 0.
  - ram_stall freezes address, lane and bank state. Stall has no effect on intake.
- Latency and throughput:
  - A beat accepted at edge N drives its first ram_we during the cycle after N, provided the other bank is empty.
  - With in_valid held high and no stall, ram_we is continuous for beats*LANES cycles.
- Simultaneous events: a bank being drained and the other bank being filled in the same cycle is legal. A bank being freed and refilled in the same cycle is not possible (registered empty flags).
- ram_addr shows ram_addr_reg at all times; it is loaded with cfg_ram_base on the cfg handshake.
- ram_selecter is held from the cfg handshake until the next cfg handshake. ram_data is 0 when no bank is full.
- in_valid outside ACTIVE is ignored. in_data is only sampled on a handshake.

Decomposition:
- Shared package dma_pkg:
  - data-type localparams DT_NONE..DT_BIAS (3'b000..3'b110);
  - state encoding IDLE/ACTIVE/DONE;
  - a clog2 function.
- Sub-module unpack_bank, instantiated twice. It holds one BEAT_WIDTH register and its full flag, with load/clear controls and a lane-select output mux.
- Pointers, counters and the FSM stay in the top level.

Test Plan:
- Single beat: cfg(type=001, base=0x10, beats=1). Beat k-th lane = 0x1000+k. Expect 16 writes to addr 0x10..0x1F with data 0x1000..0x100F, ram_selecter=001, then done one cycle after the last write.
- Streaming: beats=4, in_valid always high, no stall. Expect 64 consecutive ram_we cycles with no gaps and in_ready dropping whenever both banks are full.
- Stall and wrap: base=0xF8, beats=1, ram_stall pulsed on lanes 3 and 9. Expect addresses 0xF8..0xFF, 0x00..0x07, each word held through its stall, still 16 writes total.
- Illegal descriptors: type=000, then beats=0. Expect no in_ready, no ram_we, done=err=1 exactly one cycle after each cfg.
- Reset mid-transfer: assert rst after 5 of 32 words. Expect outputs at reset values immediately and no done. A new cfg afterwards completes normally.
- Back-to-back transfers: second cfg presented during DONE. Expect it accepted only in IDLE, with the new ram_selecter and base applied.
